alu_lockstep_pipe: RTL and testbench
====================================

Name: alu_lockstep_pipe

Overview:
- Parametrised successor to the dual 8-bit ALU user-project macro.
- Provides LANES independent ALU lanes of WIDTH bits behind a single valid/ready pipeline of PIPE register stages.
- Optional lockstep mode compares paired lanes (0/1, 2/3, ...) and counts mismatches in a saturating error counter.
- Sits in the user project area, driven from mprj_io or Wishbone glue; results return to mprj_io.

Parameters:
- WIDTH, 8, operand/result width per lane (>=2)
- LANES, 2, number of ALU lanes; must be even (elaboration-time check, $fatal otherwise)
- PIPE, 2, register stages from input acceptance to output (1..4)
- ERR_W, 8, width of saturating mismatch counter

Ports:
- clk  in  1  single clock, rising edge
- resetb  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  pipeline can accept this cycle
- a  in  LANES*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH]
- b  in  LANES*WIDTH  operand B, same packing
- sel  in  LANES*2  per-lane op: 00 add, 01 sub, 10 and, 11 or
- lockstep_en  in  1  enable pairwise comparison (sampled with operands)
- out_valid  out  1  result valid at last stage
- out_ready  in  1  downstream accepts
- result  out  LANES*WIDTH  per-lane result, same packing
- carry  out  LANES  per-lane carry/borrow flag
- mismatch  out  LANES/2  per-pair mismatch flag, qualified by out_valid
- err_count  out  ERR_W  saturating count of mismatching transfers
- err_clr  in  1  synchronous clear of err_count

Behaviour:
- Reset (resetb low, async): all stage valid bits 0, out_valid=0, result=0, carry=0, mismatch=0, err_count=0. in_ready=1 one cycle after resetb deasserts (combinationally 1 once stages are empty).
- Arithmetic, computed in stage 1:
  - add: {carry,result} = a+b in WIDTH+1 bits.
  - sub: {carry,result} = a+~b+1; carry=1 means no borrow.
  - and/or: bitwise; carry=0.
- Pipeline:
  - PIPE stages, each holding valid, result, carry and the lockstep flag.
  - Latency: PIPE cycles from accepted in_valid&in_ready to out_valid.
  - Global stall: in_ready = !out_valid | out_ready.
  - When stalled, all stages hold; no bubbles are collapsed.
  - Throughput: 1 per cycle when out_ready is held high.
- Lockstep:
  - At the output stage, mismatch[p] = stored_lockstep & out_valid & ({carry,result} of lane 2p != that of lane 2p+1).
  - With lockstep disabled, mismatch=0.
- Error counter:
  - Increments by 1 on each transfer (out_valid&out_ready) where any mismatch bit is set, regardless of how many pairs mismatch.
  - Saturates at all-ones.
  - err_clr has priority over a simultaneous increment; the result is 0.
- Boundary cases:
  - out_ready low with a full pipe: in_ready=0; inputs ignored.
  - resetb asserted mid-operation: in-flight data discarded immediately; no partial outputs.
  - lockstep_en changing mid-stream: applies per transaction, as captured at acceptance.

Optional Feature:
- Macro: ALU_FAULT_INJECT_EN.
- Defined:
  - Adds input port fault_inj (1 bit), sampled with operands.
  - When set, the LSB of lane 1's result is inverted in stage 1 before registering, so the comparator can be exercised.
- Undefined:
  - The port is absent and the datapath is untouched.

Decomposition:
- Package alu_lockstep_pkg:
  - op enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11)
  - default WIDTH/LANES constants
  - lane-slice helper function
- Sub-module alu_lane: combinational single-lane ALU (WIDTH param; a, b, sel -> result, carry), instantiated LANES times via generate.
- Pipeline registers, compare logic and counter remain in the top module.

Test Plan:
- Lanes 0 and 1 both get a=0x81, b=0x81, sel=add, lockstep_en=1, out_ready=1 -> after 2 cycles result=0x02, carry=1 on both lanes; mismatch=0; err_count=0.
- Lane0: a=0x05, b=0x07, sub. Lane1: a=0x0F, b=0xF0, or. lockstep_en=0 -> lane0=0xFE carry=0; lane1=0xFF carry=0; mismatch=0.
- Lockstep with lane0 add 0x10+0x01 and lane1 add 0x10+0x02 -> mismatch[0]=1 on the transfer cycle; err_count goes 0->1.
- Stream of 5 operand sets with out_ready low for 3 cycles mid-stream -> in_ready drops, out_valid holds with stable data, and all 5 results emerge in order with none lost or duplicated.
- Preload err_count to 0xFF via 255 mismatches, then one more mismatch -> stays 0xFF; err_clr asserted together with a mismatching transfer -> 0x00.
- Assert resetb low while 2 transactions are in flight -> out_valid=0, result=0 immediately; in_ready=1 after release; the next transaction completes with correct latency.
- With ALU_FAULT_INJECT_EN defined: identical lane inputs 0x33 and 0x33 with fault_inj=1 -> lane1 result LSB inverted, mismatch[0]=1.

Source files
------------

// File: rtl/alu_lockstep_pkg.sv
// Shared types and helpers for the lockstep ALU pipeline.
// Optional fault injection is enabled with ALU_FAULT_INJECT_EN.
package alu_lockstep_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 2;

  function automatic int lane_lo(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/alu_lane.sv
// Combinational single-lane ALU: add, sub, and, or.
// Carry is the WIDTH+1 bit of the sum; for sub it means no borrow.
module alu_lane
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    unique case (op_e'(sel))
      OP_ADD: sum = {1'b0, a} + {1'b0, b};
      OP_SUB: sum = {1'b0, a} + {1'b0, ~b}
                  + {{WIDTH{1'b0}}, 1'b1};
      OP_AND: sum = {1'b0, a & b};
      OP_OR:  sum = {1'b0, a | b};
      default: sum = '0;
    endcase
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

endmodule

// File: rtl/alu_lockstep_pipe.sv
// Multi-lane ALU behind a stalling valid/ready pipeline with lockstep
// pair comparison. ALU_FAULT_INJECT_EN adds the fault_inj input.
module alu_lockstep_pipe
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int PIPE  = 2,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES*2-1:0]     sel,
  input  logic                   lockstep_en,
`ifdef ALU_FAULT_INJECT_EN
  input  logic                   fault_inj,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       carry,
  output logic [LANES/2-1:0]     mismatch,
  output logic [ERR_W-1:0]       err_count,
  input  logic                   err_clr
);

  localparam int PAIRS = LANES / 2;
  localparam int LW    = LANES * WIDTH;

  if (LANES < 2 || LANES % 2 != 0) begin : g_lanes_chk
    $fatal(1, "LANES must be even and >= 2");
  end
  if (PIPE < 1 || PIPE > 4) begin : g_pipe_chk
    $fatal(1, "PIPE must be 1..4");
  end
  if (WIDTH < 2) begin : g_width_chk
    $fatal(1, "WIDTH must be >= 2");
  end

  logic [LW-1:0]    alu_res;
  logic [LW-1:0]    res_d;
  logic [LANES-1:0] alu_cy;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    alu_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a     (a[lane_lo(l, WIDTH) +: WIDTH]),
      .b     (b[lane_lo(l, WIDTH) +: WIDTH]),
      .sel   (sel[2*l +: 2]),
      .result(alu_res[lane_lo(l, WIDTH) +: WIDTH]),
      .carry (alu_cy[l])
    );
  end

  // Fault flips lane 1 LSB only, so pair 0 sees a mismatch.
  always_comb begin
    res_d = alu_res;
`ifdef ALU_FAULT_INJECT_EN
    res_d[WIDTH] = alu_res[WIDTH] ^ fault_inj;
`endif
  end

  logic [PIPE-1:0]  vld;
  logic [PIPE-1:0]  lsf;
  logic [LW-1:0]    res_q [PIPE];
  logic [LANES-1:0] cy_q  [PIPE];
  logic             adv;

  assign out_valid = vld[PIPE-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld <= '0;
      lsf <= '0;
      for (int i = 0; i < PIPE; i++) begin
        res_q[i] <= '0;
        cy_q[i]  <= '0;
      end
    end else if (adv) begin
      vld[0]   <= in_valid;
      lsf[0]   <= in_valid & lockstep_en;
      res_q[0] <= res_d;
      cy_q[0]  <= alu_cy;
      for (int i = 1; i < PIPE; i++) begin
        vld[i]   <= vld[i-1];
        lsf[i]   <= lsf[i-1];
        res_q[i] <= res_q[i-1];
        cy_q[i]  <= cy_q[i-1];
      end
    end
  end

  assign result = res_q[PIPE-1];
  assign carry  = cy_q[PIPE-1];

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    localparam int L0 = 2 * p;
    localparam int L1 = 2 * p + 1;
    assign mismatch[p] = lsf[PIPE-1] & out_valid &
      ({carry[L0], result[lane_lo(L0, WIDTH) +: WIDTH]} !=
       {carry[L1], result[lane_lo(L1, WIDTH) +: WIDTH]});
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_valid && out_ready && (|mismatch)
                 && !(&err_count)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_lockstep_pipe.sv
// Randomised and directed bench for alu_lockstep_pipe (defaults).
// Define ALU_FAULT_INJECT_EN to also exercise fault injection.
module tb_alu_lockstep_pipe;

  localparam int PIPE   = 2;
  localparam int ERRMAX = 255;

  logic        clk = 0;
  logic        resetb;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  sel;
  logic        lockstep_en;
  logic        fault_inj;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [1:0]  carry;
  logic [0:0]  mismatch;
  logic [7:0]  err_count;
  logic        err_clr;

  alu_lockstep_pipe dut (
    .clk        (clk),
    .resetb     (resetb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .lockstep_en(lockstep_en),
`ifdef ALU_FAULT_INJECT_EN
    .fault_inj  (fault_inj),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] res;
    logic [1:0]  cy;
    logic        mm;
  } txn_t;

  txn_t pq[$];
  int   err_m;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  logic [15:0] obs_res;
  logic [1:0]  obs_cy;
  logic        obs_mm;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic [15:0] ia, input logic [15:0] ib,
                              input logic [3:0] isel, input logic ils,
                              input logic fi);
    txn_t t;
    int x, y, s;
    t.v = 1; t.res = '0; t.cy = '0;
    for (int l = 0; l < 2; l++) begin
      x = int'(ia[l*8 +: 8]);
      y = int'(ib[l*8 +: 8]);
      case (isel[2*l +: 2])
        2'd0:    s = x + y;
        2'd1:    s = x + ((~y) & 255) + 1;
        2'd2:    s = x & y;
        default: s = x | y;
      endcase
      t.res[l*8 +: 8] = s[7:0];
      t.cy[l] = s[8];
    end
    if (fi) t.res[8] = ~t.res[8];
    t.mm = ils && ({t.cy[0], t.res[7:0]} != {t.cy[1], t.res[15:8]});
    return t;
  endfunction

  function automatic txn_t bubble();
    txn_t t;
    t.v = 0; t.res = '0; t.cy = '0; t.mm = 0;
    return t;
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < PIPE; i++) pq.push_back(bubble());
    err_m = 0;
  endtask

  task automatic step(input logic iv, input logic [15:0] ia,
                      input logic [15:0] ib, input logic [3:0] isel,
                      input logic ils, input logic ordy, input logic clr,
                      input logic fi, output logic acc);
    txn_t f;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; sel = isel;
    lockstep_en = ils; out_ready = ordy; err_clr = clr; fault_inj = fi;
    #1;
    f = pq[0];
    check("out_valid", out_valid, f.v);
    check("in_ready", in_ready, !f.v || ordy);
    check("err_count", err_count, err_m);
    if (f.v) begin
      check("result", result, f.res);
      check("carry", carry, f.cy);
      check("mismatch", mismatch, f.mm);
    end else begin
      check("mismatch_idle", mismatch, 0);
    end
    acc = iv && (!f.v || ordy);
    if (f.v && ordy) begin
      n_out++;
      obs_res = result; obs_cy = carry; obs_mm = mismatch[0];
      if (f.mm && err_m < ERRMAX) err_m++;
    end
    if (clr) err_m = 0;
    if (!f.v || ordy) begin
      void'(pq.pop_front());
      pq.push_back(iv ? mk(ia, ib, isel, ils, fi) : bubble());
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      step(0, 16'h0, 16'h0, 4'h0, 0, 1, 0, 0, acc);
  endtask

  logic acc;
  int   cyc;
  int   idx;
  int   base;
  logic [15:0] sa [5];
  logic [15:0] sb [5];
  logic [3:0]  ss [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    resetb = 0; in_valid = 0; a = 0; b = 0; sel = 0;
    lockstep_en = 0; out_ready = 0; err_clr = 0; fault_inj = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    resetb = 1;

    step(1, 16'h8181, 16'h8181, 4'b0000, 1, 1, 0, 0, acc);
    idle(PIPE + 1);
    check("add_res", obs_res, 16'h0202);
    check("add_cy", obs_cy, 2'b11);
    check("add_mm", obs_mm, 0);
    check("add_err", err_count, 0);

    step(1, 16'h0F05, 16'hF007, 4'b1101, 0, 1, 0, 0, acc);
    idle(PIPE + 1);
    check("subor_res", obs_res, 16'hFFFE);
    check("subor_cy", obs_cy, 2'b00);
    check("subor_mm", obs_mm, 0);

    step(1, 16'h1010, 16'h0201, 4'b0000, 1, 1, 0, 0, acc);
    idle(PIPE + 1);
    check("ls_mm", obs_mm, 1);
    check("ls_err", err_count, 1);

    for (int i = 0; i < 5; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom); ss[i] = 4'($urandom);
    end
    base = n_out; idx = 0; cyc = 0;
    while (idx < 5 && cyc < 50) begin
      step(1, sa[idx], sb[idx], ss[idx], 0, !(cyc >= 3 && cyc < 6),
           0, 0, acc);
      if (acc) idx++;
      cyc++;
    end
    idle(PIPE + 1);
    check("stream_count", n_out - base, 5);

    for (int i = 0; i < 260; i++)
      step(1, 16'h1010, 16'h0201, 4'b0000, 1, 1, 0, 0, acc);
    idle(PIPE + 1);
    check("sat_err", err_count, 8'hFF);
    step(1, 16'h1010, 16'h0201, 4'b0000, 1, 1, 0, 0, acc);
    step(0, 16'h0, 16'h0, 4'h0, 0, 1, 0, 0, acc);
    step(0, 16'h0, 16'h0, 4'h0, 0, 1, 1, 0, acc);
    idle(1);
    check("clr_err", err_count, 0);

    step(1, 16'h1234, 16'h5678, 4'b0100, 1, 1, 0, 0, acc);
    step(1, 16'h9ABC, 16'hDEF0, 4'b0001, 1, 1, 0, 0, acc);
    @(negedge clk);
    #1 resetb = 0;
    in_valid = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    resetb = 1;
    step(1, 16'h2211, 16'h0102, 4'b0000, 0, 1, 0, 0, acc);
    idle(PIPE + 1);
    check("post_rst_res", obs_res, 16'h2313);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ra[15:8] = ra[7:0]; rb[15:8] = rb[7:0]; rs[3:2] = rs[1:0];
      end
      step(1'($urandom), ra, rb, rs, 1'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, 0, acc);
    end
    idle(PIPE + 1);

`ifdef ALU_FAULT_INJECT_EN
    step(1, 16'h3333, 16'h0000, 4'b0000, 1, 1, 0, 1, acc);
    idle(PIPE + 1);
    check("fi_res", obs_res, 16'h3233);
    check("fi_mm", obs_mm, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
